// File: rtl/fetch_decode_exe.sv
// Y86-64 fetch, decode and execute datapath with writeback.
// Instruction bytes come from a 1 KiB byte-wide memory. All outputs are
// combinational from p_ctr, memory and the architectural state. The register
// file and the condition codes update on the rising clock edge.
module fetch_decode_exe (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               imem_we,
  input  logic [9:0]         imem_addr,
  input  logic [7:0]         imem_wdata,
  input  logic [63:0]        p_ctr,
  input  logic [63:0]        val_m,
  output logic [3:0]         in_code,
  output logic [3:0]         in_fun,
  output logic [3:0]         ra,
  output logic [3:0]         rb,
  output logic [63:0]        val_c,
  output logic [63:0]        val_p,
  output logic               flag_halt,
  output logic               in_error,
  output logic               bad_mem,
  output logic               cnd,
  output logic signed [63:0] val_a,
  output logic signed [63:0] val_b,
  output logic signed [63:0] val_e
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RSP      = 4'h4;
  localparam logic [3:0] RNONE    = 4'hF;

  logic [7:0]  imem_q [1024];
  logic [63:0] regs_q [15];
  logic        zf_q, sf_q, of_q;
  logic        zf_d, sf_d, of_d;

  logic [64:0] byteAddr [10];
  logic [7:0]  fetchByte [10];
  logic [9:0]  byteOk;
  logic [3:0]  instrLen, effLen;
  logic        hasRegs, stall, lessThan;
  logic [3:0]  srcA, srcB, dstE, dstM;

  // Instruction memory write port; the contents survive reset.
  always_ff @(posedge clock) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
  end

  // Fetch ten consecutive bytes; bytes beyond the end of memory read as zero.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      byteAddr[k]  = {1'b0, p_ctr} + 65'(k);
      byteOk[k]    = (byteAddr[k] < 65'd1024);
      fetchByte[k] = byteOk[k] ? imem_q[byteAddr[k][9:0]] : 8'h00;
    end
  end

  assign in_code = fetchByte[0][7:4];
  assign in_fun  = fetchByte[0][3:0];

  // Length, register-byte presence and function-code validity for each icode.
  always_comb begin
    instrLen = 4'd1;
    hasRegs  = 1'b0;
    in_error = 1'b0;
    case (in_code)
      I_HALT, I_NOP, I_RET: in_error = (in_fun != 4'd0);
      I_RRMOVQ: begin instrLen = 4'd2; hasRegs = 1'b1; in_error = (in_fun > 4'd6); end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        instrLen = 4'd10; hasRegs = 1'b1; in_error = (in_fun != 4'd0);
      end
      I_OPQ: begin instrLen = 4'd2; hasRegs = 1'b1; in_error = (in_fun > 4'd3); end
      I_JXX: begin instrLen = 4'd9; in_error = (in_fun > 4'd6); end
      I_CALL: begin instrLen = 4'd9; in_error = (in_fun != 4'd0); end
      I_PUSHQ, I_POPQ: begin instrLen = 4'd2; hasRegs = 1'b1; in_error = (in_fun != 4'd0); end
      default: in_error = 1'b1;
    endcase
  end

  assign effLen = in_error ? 4'd1 : instrLen;
  assign val_p  = p_ctr + {60'd0, effLen};
  assign ra     = hasRegs ? fetchByte[1][7:4] : RNONE;
  assign rb     = hasRegs ? fetchByte[1][3:0] : RNONE;

  // Any byte the instruction occupies that falls outside memory is a fetch fault.
  always_comb begin
    bad_mem = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if ((4'(k) < effLen) && !byteOk[k]) bad_mem = 1'b1;
    end
  end

  assign flag_halt = (in_code == I_HALT) && !in_error && !bad_mem;
  assign stall     = flag_halt || in_error || bad_mem;

  // Little-endian constant word; its position depends on whether a register byte precedes it.
  always_comb begin
    val_c = '0;
    case (in_code)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:
        val_c = {fetchByte[9], fetchByte[8], fetchByte[7], fetchByte[6],
                 fetchByte[5], fetchByte[4], fetchByte[3], fetchByte[2]};
      I_JXX, I_CALL:
        val_c = {fetchByte[8], fetchByte[7], fetchByte[6], fetchByte[5],
                 fetchByte[4], fetchByte[3], fetchByte[2], fetchByte[1]};
      default: val_c = '0;
    endcase
  end

  // Register-file source and destination selection.
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (in_code)
      I_RRMOVQ: begin srcA = ra; if (cnd) dstE = rb; end
      I_IRMOVQ: dstE = rb;
      I_RMMOVQ: begin srcA = ra; srcB = rb; end
      I_MRMOVQ: begin srcB = rb; dstM = ra; end
      I_OPQ:    begin srcA = ra; srcB = rb; dstE = rb; end
      I_CALL:   begin srcB = RSP; dstE = RSP; end
      I_RET:    begin srcA = RSP; srcB = RSP; dstE = RSP; end
      I_PUSHQ:  begin srcA = ra; srcB = RSP; dstE = RSP; end
      I_POPQ:   begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = ra; end
      default: ;
    endcase
  end

  assign val_a = (srcA == RNONE) ? '0 : regs_q[srcA];
  assign val_b = (srcB == RNONE) ? '0 : regs_q[srcB];

  // ALU result plus the signed-overflow flag that OPq would latch.
  always_comb begin
    val_e = '0;
    of_d  = 1'b0;
    case (in_code)
      I_OPQ: begin
        case (in_fun)
          4'd0: begin
            val_e = val_b + val_a;
            of_d  = (val_a[63] == val_b[63]) && (val_e[63] != val_b[63]);
          end
          4'd1: begin
            val_e = val_b - val_a;
            of_d  = (val_a[63] != val_b[63]) && (val_e[63] != val_b[63]);
          end
          4'd2: val_e = val_b & val_a;
          4'd3: val_e = val_b ^ val_a;
          default: val_e = '0;
        endcase
      end
      I_RRMOVQ:           val_e = val_a;
      I_IRMOVQ:           val_e = val_c;
      I_RMMOVQ, I_MRMOVQ: val_e = val_b + val_c;
      I_CALL, I_PUSHQ:    val_e = val_b - 64'sd8;
      I_RET, I_POPQ:      val_e = val_b + 64'sd8;
      default:            val_e = '0;
    endcase
  end

  assign zf_d     = (val_e == 64'sd0);
  assign sf_d     = val_e[63];
  assign lessThan = sf_q ^ of_q;

  // Branch / conditional-move condition from the stored flags.
  always_comb begin
    cnd = 1'b0;
    if ((in_code == I_RRMOVQ) || (in_code == I_JXX)) begin
      case (in_fun)
        4'd0: cnd = 1'b1;
        4'd1: cnd = lessThan || zf_q;
        4'd2: cnd = lessThan;
        4'd3: cnd = zf_q;
        4'd4: cnd = !zf_q;
        4'd5: cnd = !lessThan;
        4'd6: cnd = !lessThan && !zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  // Writeback and flag update; the memory-value port is written last so it wins a tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (!stall) begin
      if (dstE != RNONE) regs_q[dstE] <= val_e;
      if (dstM != RNONE) regs_q[dstM] <= val_m;
      if (in_code == I_OPQ) begin
        zf_q <= zf_d;
        sf_q <= sf_d;
        of_q <= of_d;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_exe.sv
// Randomized bench for fetch_decode_exe against a table-driven Y86-64 model.
module tb_fetch_decode_exe;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               imem_we;
  logic [9:0]         imem_addr;
  logic [7:0]         imem_wdata;
  logic [63:0]        p_ctr;
  logic [63:0]        val_m;
  logic [3:0]         in_code, in_fun, ra, rb;
  logic [63:0]        val_c, val_p;
  logic               flag_halt, in_error, bad_mem, cnd;
  logic signed [63:0] val_a, val_b, val_e;

  localparam logic [63:0] PARK = 64'd5000;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0]  mMem [1024];
  logic [63:0] mRegs [15];
  logic        mZf, mSf, mOf;
  int lenTab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int maxFn  [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

  // Expected outputs for the current p_ctr
  logic [3:0]  eIc, eFn, eRa, eRb;
  logic [63:0] eValC, eValP, eValA, eValB, eValE;
  logic        eHalt, eErr, eBad, eCnd;

  fetch_decode_exe dut (
    .clock(clock), .reset_n(reset_n), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .p_ctr(p_ctr), .val_m(val_m),
    .in_code(in_code), .in_fun(in_fun), .ra(ra), .rb(rb),
    .val_c(val_c), .val_p(val_p), .flag_halt(flag_halt), .in_error(in_error),
    .bad_mem(bad_mem), .cnd(cnd), .val_a(val_a), .val_b(val_b), .val_e(val_e)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] memByte(input logic [63:0] p, input int k);
    logic [64:0] a;
    a = {1'b0, p} + 65'(k);
    return (a < 65'd1024) ? mMem[a[9:0]] : 8'h00;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 15; i++) mRegs[i] = '0;
    mZf = 1'b1; mSf = 1'b0; mOf = 1'b0;
  endtask

  // Decode and execute the instruction at pc from the Y86-64 rules
  task automatic refEval(input logic [63:0] pc);
    logic [7:0] b0, b1;
    int len, start;
    logic hasReg, lt;
    logic [3:0] sA, sB;
    b0  = memByte(pc, 0);
    b1  = memByte(pc, 1);
    eIc = b0[7:4];
    eFn = b0[3:0];
    eErr  = (int'(eFn) > maxFn[eIc]);
    len   = eErr ? 1 : lenTab[eIc];
    eBad  = (({1'b0, pc} + 65'(len) - 65'd1) > 65'd1023);
    eValP = pc + 64'(len);
    hasReg = (eIc <= 4'd11) && (lenTab[eIc] == 2 || lenTab[eIc] == 10);
    eRa = hasReg ? b1[7:4] : 4'hF;
    eRb = hasReg ? b1[3:0] : 4'hF;
    start = 0;
    if (eIc >= 4'd3 && eIc <= 4'd5) start = 2;
    if (eIc == 4'd7 || eIc == 4'd8) start = 1;
    eValC = '0;
    if (start != 0)
      for (int i = 0; i < 8; i++) eValC = eValC | ({56'd0, memByte(pc, start + i)} << (8 * i));
    case (eIc)
      4'd2, 4'd4, 4'd6, 4'd10: sA = eRa;
      4'd9, 4'd11:             sA = 4'd4;
      default:                 sA = 4'hF;
    endcase
    case (eIc)
      4'd4, 4'd5, 4'd6:          sB = eRb;
      4'd8, 4'd9, 4'd10, 4'd11:  sB = 4'd4;
      default:                   sB = 4'hF;
    endcase
    eValA = (sA == 4'hF) ? 64'd0 : mRegs[sA];
    eValB = (sB == 4'hF) ? 64'd0 : mRegs[sB];
    case (eIc)
      4'd6: case (eFn)
              4'd0: eValE = eValB + eValA;
              4'd1: eValE = eValB - eValA;
              4'd2: eValE = eValB & eValA;
              4'd3: eValE = eValB ^ eValA;
              default: eValE = '0;
            endcase
      4'd2:         eValE = eValA;
      4'd3:         eValE = eValC;
      4'd4, 4'd5:   eValE = eValB + eValC;
      4'd8, 4'd10:  eValE = eValB - 64'd8;
      4'd9, 4'd11:  eValE = eValB + 64'd8;
      default:      eValE = '0;
    endcase
    lt = (mSf != mOf);
    eCnd = 1'b0;
    if (eIc == 4'd2 || eIc == 4'd7)
      case (eFn)
        4'd0: eCnd = 1'b1;
        4'd1: eCnd = lt || mZf;
        4'd2: eCnd = lt;
        4'd3: eCnd = mZf;
        4'd4: eCnd = !mZf;
        4'd5: eCnd = !lt;
        4'd6: eCnd = !lt && !mZf;
        default: eCnd = 1'b0;
      endcase
    eHalt = (eIc == 4'd0) && !eErr && !eBad;
  endtask

  // Apply the architectural effect of the last evaluated instruction
  task automatic refCommit(input logic [63:0] vm);
    logic [3:0] dE, dM;
    logic signed [64:0] wide;
    if (eHalt || eErr || eBad) return;
    dE = 4'hF; dM = 4'hF;
    if (eIc == 4'd3 || eIc == 4'd6 || (eIc == 4'd2 && eCnd)) dE = eRb;
    if (eIc >= 4'd8 && eIc <= 4'd11) dE = 4'd4;
    if (eIc == 4'd5 || eIc == 4'd11) dM = eRa;
    if (dE != 4'hF) mRegs[dE] = eValE;
    if (dM != 4'hF) mRegs[dM] = vm;
    if (eIc == 4'd6) begin
      mZf = (eValE == 64'd0);
      mSf = eValE[63];
      mOf = 1'b0;
      if (eFn == 4'd0) begin
        wide = $signed({eValB[63], eValB}) + $signed({eValA[63], eValA});
        mOf = (wide[64] != wide[63]);
      end else if (eFn == 4'd1) begin
        wide = $signed({eValB[63], eValB}) - $signed({eValA[63], eValA});
        mOf = (wide[64] != wide[63]);
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".icode"}, {60'd0, in_code}, {60'd0, eIc});
    checkOutput({tag, ".ifun"},  {60'd0, in_fun},  {60'd0, eFn});
    checkOutput({tag, ".ra"},    {60'd0, ra},      {60'd0, eRa});
    checkOutput({tag, ".rb"},    {60'd0, rb},      {60'd0, eRb});
    checkOutput({tag, ".valC"},  val_c, eValC);
    checkOutput({tag, ".valP"},  val_p, eValP);
    checkOutput({tag, ".halt"},  {63'd0, flag_halt}, {63'd0, eHalt});
    checkOutput({tag, ".err"},   {63'd0, in_error},  {63'd0, eErr});
    checkOutput({tag, ".bad"},   {63'd0, bad_mem},   {63'd0, eBad});
    checkOutput({tag, ".cnd"},   {63'd0, cnd},       {63'd0, eCnd});
    checkOutput({tag, ".valA"},  val_a, eValA);
    checkOutput({tag, ".valB"},  val_b, eValB);
    checkOutput({tag, ".valE"},  val_e, eValE);
  endtask

  // p_ctr is parked outside memory while loading, so the clock edges change no state
  task automatic loadByte(input logic [9:0] a, input logic [7:0] d);
    p_ctr = PARK;
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    @(posedge clock); #1;
    imem_we = 1'b0;
    mMem[a] = d;
  endtask

  task automatic loadInstr(input logic [63:0] addr, input logic [79:0] bytesLE, input int n);
    for (int i = 0; i < n; i++)
      if (addr + 64'(i) < 64'd1024) loadByte(10'(addr + 64'(i)), bytesLE[8*i +: 8]);
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] vm, input string tag);
    p_ctr = pc; val_m = vm;
    #2;
    refEval(pc);
    checkAll(tag);
  endtask

  task automatic stepClock();
    @(posedge clock);
    if (reset_n) refCommit(val_m);
    #1;
  endtask

  function automatic logic [79:0] mkInstr(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic [63:0] c);
    case (ic)
      4'd3, 4'd4, 4'd5:           return {c, a, b, ic, fn};
      4'd7, 4'd8:                 return {8'h00, c, ic, fn};
      4'd2, 4'd6, 4'd10, 4'd11:   return {64'd0, a, b, ic, fn};
      default:                    return {72'd0, ic, fn};
    endcase
  endfunction

  task automatic runRandom(input int n);
    logic [3:0] ic, fn, a, b;
    logic [63:0] c, pc, vm;
    int sel;
    for (int s = 0; s < n; s++) begin
      sel = $urandom_range(0, 19);
      if (sel < 6) ic = 4'd3;
      else if (sel < 18) ic = 4'($urandom_range(0, 11));
      else ic = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) fn = 4'($urandom_range(0, 15));
      else if (ic == 4'd2 || ic == 4'd7) fn = 4'($urandom_range(0, 6));
      else if (ic == 4'd6) fn = 4'($urandom_range(0, 3));
      else fn = 4'd0;
      a = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      b = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      c = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      sel = $urandom_range(0, 19);
      if (sel == 0) pc = 64'($urandom_range(1014, 1023));
      else if (sel == 1) pc = 64'($urandom_range(1024, 3000));
      else pc = 64'($urandom_range(0, 1000));
      vm = {$urandom, $urandom};
      loadInstr(pc, mkInstr(ic, fn, a, b, c), 10);
      applyStimulus(pc, vm, $sformatf("rnd%0d", s));
      stepClock();
    end
  endtask

  initial begin
    reset_n = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    p_ctr = PARK; val_m = '0;
    for (int i = 0; i < 1024; i++) mMem[i] = 8'h00;
    modelReset();
    applyStimulus(PARK, 64'd0, "reset");
    checkOutput("resetBadMem", {63'd0, bad_mem}, 64'd1);
    checkOutput("resetValP", val_p, 64'd5001);

    // Give memory a defined content while reset holds the state
    for (int i = 0; i < 1024; i++) loadByte(10'(i), 8'h00);
    reset_n = 1'b1;

    // irmovq $0x10, %rax
    loadInstr(0, {64'h10, 8'hF0, 8'h30}, 10);
    applyStimulus(0, 64'd0, "irmovq");
    checkOutput("irmovqValC", val_c, 64'd16);
    checkOutput("irmovqValE", val_e, 64'd16);
    checkOutput("irmovqValP", val_p, 64'd10);
    stepClock();
    loadInstr(20, {8'h01, 8'h20}, 2);
    applyStimulus(20, 64'd0, "rraxRead");
    checkOutput("raxIs16", val_a, 64'd16);
    stepClock();

    // subq giving zero, then jne
    loadInstr(30, {64'd5, 8'hF0, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRax5"); stepClock();
    loadInstr(30, {64'd5, 8'hF3, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRbx5"); stepClock();
    loadInstr(50, {8'h03, 8'h61}, 2);
    applyStimulus(50, 64'd0, "subq");
    checkOutput("subqValE", val_e, 64'd0);
    stepClock();
    loadInstr(60, {64'd0, 8'h74}, 9);
    applyStimulus(60, 64'd0, "jne");
    checkOutput("jneCnd", {63'd0, cnd}, 64'd0);
    stepClock();

    // addq overflowing into the sign bit, then jl
    loadInstr(30, {64'h7FFF_FFFF_FFFF_FFFF, 8'hF0, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRaxMax"); stepClock();
    loadInstr(30, {64'd1, 8'hF3, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRbx1"); stepClock();
    loadInstr(50, {8'h03, 8'h60}, 2);
    applyStimulus(50, 64'd0, "addqOvf");
    checkOutput("addqValE", val_e, 64'h8000_0000_0000_0000);
    stepClock();
    loadInstr(60, {64'd0, 8'h72}, 9);
    applyStimulus(60, 64'd0, "jl");
    checkOutput("jlCnd", {63'd0, cnd}, 64'd0);
    stepClock();

    // pushq %rax with rsp=64
    loadInstr(30, {64'd64, 8'hF4, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRsp"); stepClock();
    loadInstr(70, {8'h0F, 8'hA0}, 2);
    applyStimulus(70, 64'd0, "pushq");
    checkOutput("pushqValA", val_a, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("pushqValE", val_e, 64'd56);
    stepClock();
    loadInstr(80, {8'h40, 8'h20}, 2);
    applyStimulus(80, 64'd0, "rspRead");
    checkOutput("rspIs56", val_a, 64'd56);
    stepClock();

    // Invalid icode changes nothing; fetch past the end; halt
    loadInstr(100, {8'h43, 8'hC0}, 2);
    applyStimulus(100, 64'd0, "badIcode");
    checkOutput("badIcodeErr", {63'd0, in_error}, 64'd1);
    stepClock();
    loadInstr(80, {8'h40, 8'h20}, 2);
    applyStimulus(80, 64'd0, "rspKept");
    checkOutput("rspStill56", val_a, 64'd56);
    stepClock();
    loadInstr(1020, {64'h1234, 8'hF0, 8'h30}, 10);
    applyStimulus(1020, 64'd0, "fetchEdge");
    checkOutput("edgeBadMem", {63'd0, bad_mem}, 64'd1);
    checkOutput("edgeNoHalt", {63'd0, flag_halt}, 64'd0);
    stepClock();
    loadInstr(200, {8'h00, 8'h00}, 2);
    applyStimulus(200, 64'd0, "halt");
    checkOutput("haltFlag", {63'd0, flag_halt}, 64'd1);
    stepClock();

    runRandom(200);

    // Mid-program reset: make rax/rbx nonzero and ZF clear, then reset between edges
    loadInstr(30, {64'd3, 8'hF0, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRax3"); stepClock();
    loadInstr(30, {64'd4, 8'hF3, 8'h30}, 10); applyStimulus(30, 64'd0, "ldRbx4"); stepClock();
    loadInstr(50, {8'h03, 8'h60}, 2); applyStimulus(50, 64'd0, "addq7"); stepClock();
    loadInstr(310, {64'd0, 8'h73}, 9);
    applyStimulus(50, 64'd0, "preReset");
    reset_n = 1'b0;
    modelReset();
    applyStimulus(50, 64'd0, "inReset");
    checkOutput("resetRax", val_a, 64'd0);
    checkOutput("resetRbx", val_b, 64'd0);
    applyStimulus(310, 64'd0, "resetJe");
    checkOutput("resetZf", {63'd0, cnd}, 64'd1);
    stepClock();
    reset_n = 1'b1;

    runRandom(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode_exe.md
FETCH_DECODE_EXE -- requirements
Module: fetch_decode_exe

Interface
REQ-001 SHALL have port clock, input, 1 bit, single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have ports imem_we (1 bit), imem_addr (10 bits) and imem_wdata (8 bits), all inputs, forming a byte-wide instruction-memory write port.
REQ-004 SHALL have port p_ctr, input, 64 bits, current program counter.
REQ-005 SHALL have port val_m, input, 64 bits, data-memory read value for writeback.
REQ-006 SHALL have ports in_code and in_fun, outputs, 4 bits each, instruction byte high and low nibble.
REQ-007 SHALL have ports ra and rb, outputs, 4 bits each, register specifiers; 4'hF when absent.
REQ-008 SHALL have ports val_c and val_p, outputs, 64 bits each: constant word and next sequential PC.
REQ-009 SHALL have ports flag_halt, in_error, bad_mem and cnd, outputs, 1 bit each: halt, invalid instruction, out-of-range fetch, and branch/move condition.
REQ-010 SHALL have ports val_a, val_b and val_e, outputs, 64-bit signed: register operands and ALU result.

Function
REQ-011 SHALL hold 1024 bytes of instruction memory, written at posedge when imem_we=1; the memory is not cleared by reset.
REQ-012 SHALL fetch combinationally from p_ctr using Y86-64 encoding: icode 0 halt, 1 nop, 2 rrmovq/cmovXX (fn 0-6), 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq (fn 0 add, 1 sub, 2 and, 3 xor), 7 jXX (fn 0-6), 8 call, 9 ret, A pushq, B popq.
REQ-013 SHALL compute val_p = p_ctr + length; length is 1 for icodes 0,1,9; 2 for 2,6,A,B; 10 for 3,4,5; 9 for 7,8.
REQ-014 SHALL assemble val_c little-endian from byte p_ctr+2 (icodes 3,4,5) or byte p_ctr+1 (icodes 7,8); val_c=0 otherwise.
REQ-015 SHALL assert in_error for icode > B or for an undefined fn for that icode (fn != 0 except icodes 2, 6, 7); on error val_p = p_ctr+1.
REQ-016 SHALL assert bad_mem when any byte of the instruction lies above address 1023; out-of-range bytes read 0.
REQ-017 SHALL assert flag_halt when icode=0 and neither in_error nor bad_mem is set.
REQ-018 SHALL contain 15 64-bit registers (0-14, rsp=4); specifier F means none.
REQ-019 SHALL select srcA = ra for icodes 2,4,6,A; rsp for 9,B; none otherwise.
REQ-020 SHALL select srcB = rb for icodes 4,5,6; rsp for 8,9,A,B; none otherwise.
REQ-021 SHALL drive val_a and val_b combinationally; a none source reads 0.
REQ-022 SHALL compute val_e as follows: OPq = val_b op val_a (sub is val_b-val_a, 64-bit wrap); 2 = val_a; 3 = val_c; 4,5 = val_b+val_c; 8,A = val_b-8; 9,B = val_b+8; others 0.
REQ-023 SHALL keep condition codes ZF, SF, OF, updated at posedge only for a valid OPq; OF is set on signed add/sub overflow and cleared for and/xor.
REQ-024 SHALL compute cnd for icodes 2 and 7 as: fn0 1; fn1 (SF^OF)|ZF; fn2 SF^OF; fn3 ZF; fn4 !ZF; fn5 !(SF^OF); fn6 !(SF^OF)&!ZF; cnd=0 for all other icodes.
REQ-025 SHALL write back at posedge: dstE = rb for 3, 6, and for 2 when cnd=1; rsp for 8,9,A,B; written with val_e.
REQ-026 SHALL write back at posedge: dstM = ra for 5,B, written with val_m.
REQ-027 SHALL give the dstM write priority when dstE and dstM are the same register.
REQ-028 SHALL suppress all register and condition-code writes while flag_halt, in_error or bad_mem is set.

Reset
REQ-029 SHALL, while reset_n=0, immediately clear all registers to 0 and set ZF=1, SF=0, OF=0.
REQ-030 SHALL keep all outputs purely combinational from p_ctr, instruction memory and state, so outputs settle in the same cycle.

Verification
REQ-031 SHALL pass: irmovq 0x10,%rax (30 F0 10 00..) at p_ctr 0 -> val_c=16, val_e=16, val_p=10; after posedge rax=16.
REQ-032 SHALL pass: rax=5, rbx=5, subq %rax,%rbx (61 03) -> val_e=0; after posedge ZF=1 and jne (fn4) gives cnd=0.
REQ-033 SHALL pass: addq with rax=0x7FFF_FFFF_FFFF_FFFF, rbx=1 -> val_e=0x8000_0000_0000_0000; after posedge SF=1, OF=1, jl gives cnd=0.
REQ-034 SHALL pass: pushq %rax with rsp=64 -> val_a=rax, val_e=56; after posedge rsp=56.
REQ-035 SHALL pass: byte 0xC0 -> in_error=1 and no state change; p_ctr=1020 holding irmovq -> bad_mem=1; byte 00 -> flag_halt=1.
REQ-036 SHALL pass: reset_n low mid-program -> all registers 0 and ZF=1 before the next clock edge.
